// File: rtl/seq_ctrl_if.sv
// Memory-port and execute-unit bundle; the sequencer is the only master of both.
interface seq_ctrl_if #(parameter int AW = 10);
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic [15:0]   exe_result;
    logic          exe_start;
    logic [1:0]    exe_iden;
    logic [3:0]    exe_opcode;
    logic [15:0]   operand;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output exe_start, exe_iden, exe_opcode, operand,
        input  mem_rdata, exe_result
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  exe_start, exe_iden, exe_opcode, operand,
        output mem_rdata, exe_result
    );
endinterface

// File: rtl/seq_ctrl.sv
// Instruction sequencer: fetch, decode, operand read, execute strobe, store, halt.
// Every output is a register loaded from the values implied by the next state.
module seq_ctrl #(
    parameter int            AW         = 10,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    seq_ctrl_if.master    bus,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPREAD, S_OLATCH, S_EXEC, S_STORE, S_HALT
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   ir, ir_nxt;
    logic [AW-1:0] pc_nxt;

    logic          rd_nxt, wr_nxt, start_nxt, busy_nxt, halted_nxt;
    logic [AW-1:0] addr_nxt;
    logic [15:0]   wdata_nxt, operand_nxt;
    logic [1:0]    iden_nxt;
    logic [3:0]    opcode_nxt;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        rd_nxt      = 1'b0;
        wr_nxt      = 1'b0;
        start_nxt   = 1'b0;
        addr_nxt    = bus.mem_addr;
        wdata_nxt   = bus.mem_wdata;
        iden_nxt    = bus.exe_iden;
        opcode_nxt  = bus.exe_opcode;
        operand_nxt = bus.operand;

        case (state)
            S_IDLE, S_HALT: begin
                if (run) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = START_ADDR;
                end
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                ir_nxt = bus.mem_rdata;
                pc_nxt = pc + AW'(1);
                case (bus.mem_rdata[15:14])
                    2'b00, 2'b01: state_nxt = S_OPREAD;
                    2'b10:        state_nxt = S_STORE;
                    default:      state_nxt = S_HALT;
                endcase
            end
            S_OPREAD: state_nxt = S_OLATCH;
            S_OLATCH: begin
                operand_nxt = bus.mem_rdata;
                state_nxt   = S_EXEC;
            end
            S_EXEC:   state_nxt = S_FETCH;
            S_STORE:  state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase

        // Outputs are those of the state being entered, so they appear in that state's cycle.
        case (state_nxt)
            S_FETCH: begin
                rd_nxt   = 1'b1;
                addr_nxt = pc_nxt;
            end
            S_OPREAD: begin
                rd_nxt   = 1'b1;
                addr_nxt = ir_nxt[AW-1:0];
            end
            S_STORE: begin
                // Accumulator is captured at the edge that enters STORE; the last
                // EXEC is at least two cycles older, so its result has landed.
                wr_nxt    = 1'b1;
                addr_nxt  = ir_nxt[AW-1:0];
                wdata_nxt = bus.exe_result;
            end
            S_EXEC: begin
                start_nxt  = 1'b1;
                iden_nxt   = ir_nxt[15:14];
                opcode_nxt = ir_nxt[13:10];
            end
            default: ;
        endcase

        busy_nxt   = !(state_nxt == S_IDLE || state_nxt == S_HALT);
        halted_nxt = (state_nxt == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= START_ADDR;
            ir             <= '0;
            bus.mem_rd     <= 1'b0;
            bus.mem_wr     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.exe_start  <= 1'b0;
            bus.exe_iden   <= '0;
            bus.exe_opcode <= '0;
            bus.operand    <= '0;
            busy           <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            ir             <= ir_nxt;
            bus.mem_rd     <= rd_nxt;
            bus.mem_wr     <= wr_nxt;
            bus.mem_addr   <= addr_nxt;
            bus.mem_wdata  <= wdata_nxt;
            bus.exe_start  <= start_nxt;
            bus.exe_iden   <= iden_nxt;
            bus.exe_opcode <= opcode_nxt;
            bus.operand    <= operand_nxt;
            busy           <= busy_nxt;
            halted         <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: memory + execute environment, ISA-level reference model
// that predicts execute strobes, stores and halt timing from instruction costs.
module tb_seq_ctrl;
    localparam int AW = 10;
    localparam int MW = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic run_s = 1'b0;
    logic ld = 1'b0;
    always #5 clk = ~clk;

    seq_ctrl_if #(.AW(AW)) bus ();
    seq_ctrl_if #(.AW(4))  sbus ();

    logic [AW-1:0] pc;
    logic          busy, halted;
    logic [3:0]    pc_s;
    logic          busy_s, halted_s;

    seq_ctrl #(.AW(AW), .START_ADDR(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .bus(bus.master),
        .pc(pc), .busy(busy), .halted(halted)
    );

    seq_ctrl #(.AW(4), .START_ADDR(4'd15)) dut_s (
        .clk(clk), .rst_n(rst_n), .run(run_s), .bus(sbus.master),
        .pc(pc_s), .busy(busy_s), .halted(halted_s)
    );

    function automatic logic [15:0] alu(input logic [1:0] iden, input logic [3:0] opc,
                                        input logic [15:0] a, input logic [15:0] b);
        if (iden == 2'b00) return b;
        case (opc)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            default: return a + b + 16'(opc);
        endcase
    endfunction

    // environment: synchronous memory and accumulator
    logic [15:0] img  [MW];
    logic [15:0] mem  [MW];
    logic [15:0] img_s [16];
    logic [15:0] smem [16];
    logic [15:0] acc = 16'h0;
    logic [15:0] sacc = 16'h0;

    assign bus.exe_result  = acc;
    assign sbus.exe_result = sacc;

    always @(posedge clk) begin
        if (ld) for (int i = 0; i < MW; i++) mem[i] <= img[i];
        else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 16'($urandom);
        if (bus.exe_start) acc <= alu(bus.exe_iden, bus.exe_opcode, acc, bus.operand);
    end

    always @(posedge clk) begin
        if (ld) for (int i = 0; i < 16; i++) smem[i] <= img_s[i];
        else if (sbus.mem_wr) smem[sbus.mem_addr] <= sbus.mem_wdata;
        sbus.mem_rdata <= sbus.mem_rd ? smem[sbus.mem_addr] : 16'($urandom);
        if (sbus.exe_start) sacc <= alu(sbus.exe_iden, sbus.exe_opcode, sacc, sbus.operand);
    end

    // event = {is_wr, iden, opcode, addr, value, cycle relative to first FETCH}
    typedef logic [52:0] ev_t;
    function automatic ev_t mk_ev(input logic w, input logic [1:0] i, input logic [3:0] o,
                                  input logic [9:0] a, input logic [15:0] v, input int c);
        return {w, i, o, a, v, c[19:0]};
    endfunction

    int   cyc = 0;
    int   base = 0;
    ev_t  act_q[$];
    int   viol_rdwr = 0, viol_dbl = 0, viol_bh = 0;
    logic prev_start = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.exe_start)
            act_q.push_back(mk_ev(1'b0, bus.exe_iden, bus.exe_opcode, 10'd0, bus.operand, cyc - base));
        if (bus.mem_wr)
            act_q.push_back(mk_ev(1'b1, 2'd0, 4'd0, bus.mem_addr, bus.mem_wdata, cyc - base));
        if (bus.mem_rd && bus.mem_wr) viol_rdwr <= viol_rdwr + 1;
        if (bus.exe_start && prev_start) viol_dbl <= viol_dbl + 1;
        if (busy && halted) viol_bh <= viol_bh + 1;
        prev_start <= bus.exe_start;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.exe_start,
                    bus.exe_iden, bus.exe_opcode, bus.operand, busy, halted});
    endfunction

    // reference model: interpret the program with per-class cycle costs
    ev_t           exp_q[$];
    int            exp_halt;
    logic [AW-1:0] exp_pc;
    logic [15:0]   mm [MW];

    task automatic model_run(input logic [15:0] a0);
        logic [AW-1:0] p;
        logic [AW-1:0] ad;
        logic [15:0]   ins, a;
        int            c;
        p = '0; c = 0; a = a0;
        exp_q.delete();
        mm = img;
        exp_halt = -1;
        exp_pc = '0;
        for (int n = 0; n < 5000; n++) begin
            ins = mm[p];
            ad  = ins[AW-1:0];
            p   = p + 10'd1;
            case (ins[15:14])
                2'b00, 2'b01: begin
                    exp_q.push_back(mk_ev(1'b0, ins[15:14], ins[13:10], 10'd0, mm[ad], c + 4));
                    a = alu(ins[15:14], ins[13:10], a, mm[ad]);
                    c += 5;
                end
                2'b10: begin
                    exp_q.push_back(mk_ev(1'b1, 2'd0, 4'd0, ad, a, c + 2));
                    mm[ad] = a;
                    c += 3;
                end
                default: begin
                    exp_halt = c + 2;
                    exp_pc = p;
                    return;
                end
            endcase
        end
    endtask

    task automatic load_mem();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int pulse_at);
        int            st, bad_busy, halt_rel, nexp, nact;
        bit            done;
        logic [AW-1:0] pc_hold;
        bad_busy = 0; done = 1'b0; halt_rel = -1; pc_hold = '0;
        load_mem();
        model_run(acc);
        st = act_q.size();
        run = 1'b1; base = cyc + 1;
        @(negedge clk); run = 1'b0;
        for (int k = 0; k < exp_halt + 20 && !done; k++) begin
            if (k == pulse_at) begin pc_hold = pc; run = 1'b1; end
            if (pulse_at >= 0 && k == pulse_at + 1) begin
                run = 1'b0;
                chk({tag, "_run_ignored_pc"}, 64'(pc), 64'(pc_hold));
            end
            if (halted) begin done = 1'b1; halt_rel = k; end
            else begin
                if (!busy) bad_busy++;
                @(negedge clk);
            end
        end
        chk({tag, "_halt_cycle"}, 64'(halt_rel), 64'(exp_halt));
        chk({tag, "_pc_final"}, 64'(pc), 64'(exp_pc));
        chk({tag, "_busy_while_running"}, 64'(bad_busy), 64'd0);
        nact = act_q.size() - st;
        nexp = exp_q.size();
        chk({tag, "_event_count"}, 64'(nact), 64'(nexp));
        for (int i = 0; i < nexp && i < nact; i++) begin
            if (act_q[st + i] !== exp_q[i]) begin
                chk({tag, "_event"}, 64'(act_q[st + i]), 64'(exp_q[i]));
                break;
            end
            if (i == nexp - 1) chk({tag, "_event_last"}, 64'(act_q[st + i]), 64'(exp_q[i]));
        end
    endtask

    task automatic gen_prog(input int len);
        for (int i = 0; i < MW; i++) img[i] = 16'($urandom);
        for (int i = 0; i < len - 1; i++)
            img[i] = {2'($urandom_range(0, 2)), 4'($urandom), 10'(1000 + $urandom_range(0, 23))};
        img[len - 1] = 16'hC000;
    endtask

    task automatic prog_basic();
        for (int i = 0; i < MW; i++) img[i] = 16'h0;
        img[0] = 16'h0005; img[1] = 16'h4406; img[2] = 16'h8007; img[3] = 16'hC000;
        img[5] = 16'h1234; img[6] = 16'h0003;
    endtask

    // abort an instruction with reset; wait_wr selects STORE vs EXEC as the victim
    task automatic reset_abort(input string tag, input bit wait_wr);
        int          n0;
        bit          hit;
        logic [15:0] acc0;
        hit = 1'b0;
        prog_basic();
        load_mem();
        run = 1'b1; @(negedge clk); run = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (wait_wr ? bus.mem_wr : bus.exe_start) hit = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_reached"}, 64'(hit), 64'd1);
        acc0 = acc;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_outputs_reset"}, outs(), 64'd0);
        chk({tag, "_pc_reset"}, 64'(pc), 64'd0);
        n0 = act_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk({tag, "_no_events_after"}, 64'(act_q.size() - n0), 64'd0);
        chk({tag, "_mem7_untouched"}, 64'(mem[7]), 64'h0);
        chk({tag, "_acc_untouched"}, 64'(acc), 64'(acc0));
        chk({tag, "_idle"}, 64'({busy, halted}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) img[i] = 16'h0;
        for (int i = 0; i < 16; i++) img_s[i] = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        chk("reset_pc", 64'(pc), 64'd0);
        chk("reset_pc_small", 64'(pc_s), 64'd15);
        chk("reset_small_outputs", 64'({sbus.mem_rd, sbus.mem_wr, sbus.exe_start, busy_s, halted_s}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LOAD 5 then HALT
        img[0] = 16'h0005; img[5] = 16'h1234; img[1] = 16'hC000;
        run_prog("load_halt", -1);
        chk("load_halt_operand", 64'(bus.operand), 64'h1234);
        chk("load_halted", 64'(halted), 64'd1);

        // LOAD, ADD, STORE, HALT; restarts from HALT
        prog_basic();
        run_prog("add_store", -1);
        chk("add_store_mem7", 64'(mem[7]), 64'h1237);

        // RUN in OPREAD is ignored
        prog_basic();
        run_prog("run_in_opread", 2);

        // PC wrap on the 4-bit instance
        img_s[15] = 16'h0003; img_s[3] = 16'hABCD; img_s[0] = 16'hC000;
        load_mem();
        run_s = 1'b1; @(negedge clk); run_s = 1'b0;
        chk("wrap_fetch0", 64'({sbus.mem_rd, sbus.mem_addr}), 64'({1'b1, 4'd15}));
        repeat (2) @(negedge clk);
        chk("wrap_pc_after_decode", 64'(pc_s), 64'd0);
        chk("wrap_opread", 64'({sbus.mem_rd, sbus.mem_addr}), 64'({1'b1, 4'd3}));
        repeat (2) @(negedge clk);
        chk("wrap_exec", 64'({sbus.exe_start, sbus.exe_iden, sbus.operand}), 64'({1'b1, 2'd0, 16'hABCD}));
        @(negedge clk);
        chk("wrap_next_fetch", 64'({sbus.mem_rd, sbus.mem_addr}), 64'({1'b1, 4'd0}));
        repeat (2) @(negedge clk);
        chk("wrap_halted", 64'({halted_s, pc_s}), 64'({1'b1, 4'd1}));

        // random programs including the long one
        gen_prog(1000); run_prog("rnd_long", -1);
        for (int r = 0; r < 3; r++) begin
            gen_prog(20 + r * 15);
            run_prog("rnd_short", -1);
        end

        reset_abort("rst_in_store", 1'b1);
        reset_abort("rst_in_exec", 1'b0);

        // fresh run after reset
        prog_basic();
        run_prog("after_reset", -1);

        chk("never_rd_and_wr", 64'(viol_rdwr), 64'd0);
        chk("no_double_start", 64'(viol_dbl), 64'd0);
        chk("busy_excl_halted", 64'(viol_bh), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
